// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - shared memory port between the sequencer and the memory system
interface core_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_is_fetch,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_is_fetch,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control FSM owning PC, IR and the shared memory port
// Optional performance counters enabled by CORE_SEQUENCER_PERF_COUNTERS_EN.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  core_sequencer_if.master          mem,
  output logic [31:0]               instr,
  input  logic                      dec_reg_wren,
  input  logic                      dec_ram_wren,
  input  logic                      dec_reg_write_data_src,
  input  logic [31:0]               pc_next,
  output logic [31:0]               pc,
  output logic                      reg_wren,
  input  logic                      halt_req,
  output logic                      halted,
  output logic                      trap,
  output logic                      retire,
  output logic [31:0]               cycle_count,
  output logic [31:0]               instret_count
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEM       = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       opcode_legal;
  logic       run;

  always_comb begin
    opcode_legal = 1'b0;
    case (instr[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:     if (mem.mem_ready) state_next = ST_DECODE;
      ST_DECODE:    state_next = opcode_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE:   state_next = (dec_ram_wren || dec_reg_write_data_src) ? ST_MEM : ST_WRITEBACK;
      ST_MEM:       if (mem.mem_ready) state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = halt_req ? ST_HALTED : ST_FETCH;
      ST_HALTED:    if (!halt_req) state_next = ST_FETCH;
      ST_TRAP:      state_next = ST_TRAP;
      default:      state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      instr <= NOP;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && mem.mem_ready) instr <= mem.mem_rdata;
      if (state == ST_WRITEBACK) pc <= pc_next;
    end
  end

  // Reset masks every strobe so an aborted request or write never leaks out.
  assign run              = ~rst;
  assign mem.mem_req      = run && (state == ST_FETCH || state == ST_MEM);
  assign mem.mem_we       = run && (state == ST_MEM) && dec_ram_wren;
  assign mem.mem_is_fetch = (state == ST_FETCH);
  assign reg_wren         = run && (state == ST_WRITEBACK) && dec_reg_wren;
  assign retire           = run && (state == ST_WRITEBACK);
  assign halted           = run && (state == ST_HALTED);
  assign trap             = run && (state == ST_TRAP);

`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'h1;
      if (retire) instret_q <= instret_q + 32'h1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = 32'h0;
  assign instret_count = 32'h0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] SW   = 32'h0020_a023;
  localparam logic [31:0] BEQ  = 32'h0020_8063;
  localparam logic [31:0] LW   = 32'h0000_a103;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        dec_reg_wren;
  logic        dec_ram_wren;
  logic        dec_reg_write_data_src;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        reg_wren;
  logic        halt_req;
  logic        halted;
  logic        trap;
  logic        retire;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_req  = 0;
  int cnt_wren = 0;
  int cnt_ret  = 0;
  int snap_req, snap_wren, snap_ret;

  core_sequencer_if bus ();

  core_sequencer #(.RESET_PC(32'h0)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem                    (bus),
    .instr                  (instr),
    .dec_reg_wren           (dec_reg_wren),
    .dec_ram_wren           (dec_ram_wren),
    .dec_reg_write_data_src (dec_reg_write_data_src),
    .pc_next                (pc_next),
    .pc                     (pc),
    .reg_wren               (reg_wren),
    .halt_req               (halt_req),
    .halted                 (halted),
    .trap                   (trap),
    .retire                 (retire),
    .cycle_count            (cycle_count),
    .instret_count          (instret_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_req) cnt_req++;
    if (reg_wren)    cnt_wren++;
    if (retire)      cnt_ret++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #3;
  endtask

  task automatic snapshot();
    snap_req  = cnt_req;
    snap_wren = cnt_wren;
    snap_ret  = cnt_ret;
  endtask

  task automatic set_instr(input logic [31:0] word, input logic rw, input logic sw, input logic ld,
                           input logic [31:0] npc);
    bus.mem_rdata          = word;
    dec_reg_wren           = rw;
    dec_ram_wren           = sw;
    dec_reg_write_data_src = ld;
    pc_next                = npc;
    bus.mem_ready          = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    halt_req = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check_eq("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check_eq("rst_retire", {31'h0, retire}, 32'h0);
    check_eq("rst_halted", {31'h0, halted}, 32'h0);
    check_eq("rst_trap", {31'h0, trap}, 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, 32'h0000_0013);

    // ADDI: fetch, decode, execute, writeback
    rst = 1'b0;
    set_instr(ADDI, 1'b1, 1'b0, 1'b0, 32'h4);
    #1;
    check_eq("addi_c1_req", {31'h0, bus.mem_req}, 32'h1);
    check_eq("addi_c1_is_fetch", {31'h0, bus.mem_is_fetch}, 32'h1);
    check_eq("addi_c1_we", {31'h0, bus.mem_we}, 32'h0);
    next_cycle();
    check_eq("addi_c2_instr", instr, ADDI);
    check_eq("addi_c2_req", {31'h0, bus.mem_req}, 32'h0);
    next_cycle();
    check_eq("addi_c3_wren", {31'h0, reg_wren}, 32'h0);
    next_cycle();
    check_eq("addi_c4_wren", {31'h0, reg_wren}, 32'h1);
    check_eq("addi_c4_retire", {31'h0, retire}, 32'h1);
    check_eq("addi_c4_pc", pc, 32'h0);
    next_cycle();
    check_eq("addi_c5_pc", pc, 32'h4);
    check_eq("addi_c5_req", {31'h0, bus.mem_req}, 32'h1);
    check_eq("addi_c5_retire", {31'h0, retire}, 32'h0);

    // SW with three wait cycles in MEM
    set_instr(SW, 1'b0, 1'b1, 1'b0, 32'h10);
    snapshot();
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      check_eq("sw_mem_req", {31'h0, bus.mem_req}, 32'h1);
      check_eq("sw_mem_we", {31'h0, bus.mem_we}, 32'h1);
      check_eq("sw_mem_is_fetch", {31'h0, bus.mem_is_fetch}, 32'h0);
      check_eq("sw_mem_retire", {31'h0, retire}, 32'h0);
    end
    next_cycle();
    check_eq("sw_c8_retire", {31'h0, retire}, 32'h1);
    check_eq("sw_c8_we", {31'h0, bus.mem_we}, 32'h0);
    next_cycle();
    check_eq("sw_no_wren", cnt_wren - snap_wren, 32'h0);
    check_eq("sw_pc", pc, 32'h10);

    // BEQ taken: pc 0x10 -> 0x40
    set_instr(BEQ, 1'b0, 1'b0, 1'b0, 32'h40);
    snapshot();
    next_cycle();
    next_cycle();
    next_cycle();
    check_eq("beq_wb_retire", {31'h0, retire}, 32'h1);
    check_eq("beq_wb_pc", pc, 32'h10);
    next_cycle();
    check_eq("beq_fetch_pc", pc, 32'h40);
    check_eq("beq_fetch_req", {31'h0, bus.mem_req & bus.mem_is_fetch}, 32'h1);
    check_eq("beq_no_wren", cnt_wren - snap_wren, 32'h0);

    // Illegal word traps; halt_req and decoder enables must have no effect
    set_instr(32'h0, 1'b1, 1'b1, 1'b0, 32'h80);
    next_cycle();
    check_eq("ill_instr", instr, 32'h0);
    next_cycle();
    halt_req = 1'b1;
    snapshot();
    for (int i = 0; i < 20; i++) begin
      check_eq("ill_trap", {31'h0, trap}, 32'h1);
      next_cycle();
    end
    check_eq("ill_no_req", cnt_req - snap_req, 32'h0);
    check_eq("ill_no_wren", cnt_wren - snap_wren, 32'h0);
    check_eq("ill_no_retire", cnt_ret - snap_ret, 32'h0);
    check_eq("ill_pc_frozen", pc, 32'h40);
    check_eq("ill_halted", {31'h0, halted}, 32'h0);
    rst = 1'b1;
    halt_req = 1'b0;
    #1;
    check_eq("ill_rst_trap", {31'h0, trap}, 32'h0);
    next_cycle();
    rst = 1'b0;
    set_instr(LW, 1'b1, 1'b0, 1'b1, 32'h4);
    #1;
    check_eq("ill_refetch_req", {31'h0, bus.mem_req & bus.mem_is_fetch}, 32'h1);
    check_eq("ill_refetch_pc", pc, 32'h0);
    check_eq("ill_refetch_trap", {31'h0, trap}, 32'h0);

    // LW aborted by reset during its MEM wait
    snapshot();
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    next_cycle();
    check_eq("lw_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check_eq("lw_mem_is_fetch", {31'h0, bus.mem_is_fetch}, 32'h0);
    check_eq("lw_mem_we", {31'h0, bus.mem_we}, 32'h0);
    next_cycle();
    rst = 1'b1;
    #1;
    check_eq("lw_rst_req", {31'h0, bus.mem_req}, 32'h0);
    next_cycle();
    rst = 1'b0;
    set_instr(ADDI, 1'b1, 1'b0, 1'b0, 32'h4);
    #1;
    check_eq("lw_abort_fetch", {31'h0, bus.mem_req & bus.mem_is_fetch}, 32'h1);
    check_eq("lw_abort_pc", pc, 32'h0);
    check_eq("lw_abort_no_wren", cnt_wren - snap_wren, 32'h0);
    check_eq("lw_abort_no_retire", cnt_ret - snap_ret, 32'h0);

    // ADDI with halt_req raised during EXECUTE
    next_cycle();
    next_cycle();
    halt_req = 1'b1;
    next_cycle();
    check_eq("halt_wb_retire", {31'h0, retire}, 32'h1);
    check_eq("halt_wb_wren", {31'h0, reg_wren}, 32'h1);
    next_cycle();
    check_eq("halt_halted", {31'h0, halted}, 32'h1);
    check_eq("halt_no_req", {31'h0, bus.mem_req}, 32'h0);
    check_eq("halt_pc", pc, 32'h4);
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
    check_eq("halt_cycles_a", cycle_count, 32'd4);
    check_eq("halt_instret", instret_count, 32'd1);
`else
    check_eq("halt_cycles_off", cycle_count, 32'h0);
    check_eq("halt_instret_off", instret_count, 32'h0);
`endif
    next_cycle();
    next_cycle();
    halt_req = 1'b0;
    #1;
    check_eq("halt_still_halted", {31'h0, halted}, 32'h1);
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
    check_eq("halt_cycles_b", cycle_count, 32'd6);
`endif
    next_cycle();
    check_eq("resume_halted", {31'h0, halted}, 32'h0);
    check_eq("resume_fetch", {31'h0, bus.mem_req & bus.mem_is_fetch}, 32'h1);
    check_eq("resume_pc", pc, 32'h4);
`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
    check_eq("resume_cycles", cycle_count, 32'd7);
    check_eq("resume_instret", instret_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
